// File: rtl/mips32_pkg.sv
// mips32_pkg: definitions shared by the MIPS32 fetch stage and its queue.
//   RESET_PC_DEFAULT : default first fetch address after reset
//   fetch_slot_t     : one fetch queue entry {pc, instr, filled}
//   pc_plus4         : sequential next address, wraps modulo 2^32
package mips32_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        filled;
  } fetch_slot_t;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/mips32_fetch_if.sv
// mips32_fetch_if: instruction-memory, redirect and decode-side signals of
// the fetch stage.
//   imem_req_valid/ready/addr : fetch request handshake
//   imem_rsp_valid/data       : in-order response, no backpressure
//   redirect_valid/pc         : taken branch/jump restart from EX
//   id_valid/ready            : decode handshake
//   id_instr/id_pc/id_pc_plus4: instruction handed to decode
// master = fetch stage, slave = memory/pipeline environment.
interface mips32_fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;

  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, id_pc_plus4,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, id_pc_plus4,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/mips32_fetch_queue.sv
// mips32_fetch_queue: 2-entry in-order fetch slot queue.
//   clk, rst       : clock, async active-low reset
//   alloc/alloc_pc : reserve a slot for a fired request (filled = 0)
//   fill/fill_instr: write the oldest unfilled slot with a response
//   pop            : retire the head slot (caller guarantees it is filled)
//   flush          : free every slot
//   head           : head slot contents
//   n_alloc        : slots allocated (0..2)
//   n_unfilled     : allocated slots still waiting for a response
module mips32_fetch_queue
  import mips32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        alloc,
  input  logic [31:0] alloc_pc,
  input  logic        fill,
  input  logic [31:0] fill_instr,
  input  logic        pop,
  input  logic        flush,
  output fetch_slot_t head,
  output logic [1:0]  n_alloc,
  output logic [1:0]  n_unfilled
);

  fetch_slot_t slot_q [2];
  logic        head_q;
  logic [1:0]  n_alloc_q;
  logic [1:0]  n_filled_q;
  logic        alloc_idx;
  logic        fill_idx;
  logic        fill_ok;

  // Filled slots always form a prefix starting at head, so the next slot to
  // allocate and the next slot to fill are both offsets from head.
  assign alloc_idx = head_q ^ n_alloc_q[0];
  assign fill_idx  = head_q ^ n_filled_q[0];
  // A response with no slot waiting for it is ignored rather than corrupting state.
  assign fill_ok   = fill & (n_filled_q != n_alloc_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_q[0]  <= '0;
      slot_q[1]  <= '0;
      head_q     <= 1'b0;
      n_alloc_q  <= 2'd0;
      n_filled_q <= 2'd0;
    end else if (flush) begin
      slot_q[0].filled <= 1'b0;
      slot_q[1].filled <= 1'b0;
      n_alloc_q        <= 2'd0;
      n_filled_q       <= 2'd0;
    end else begin
      if (alloc) begin
        slot_q[alloc_idx] <= '{pc: alloc_pc, instr: 32'h0, filled: 1'b0};
      end
      if (fill_ok) begin
        slot_q[fill_idx].instr  <= fill_instr;
        slot_q[fill_idx].filled <= 1'b1;
      end
      if (pop) begin
        slot_q[head_q].filled <= 1'b0;
        head_q                <= ~head_q;
      end
      n_alloc_q  <= n_alloc_q + {1'b0, alloc} - {1'b0, pop};
      n_filled_q <= n_filled_q + {1'b0, fill_ok} - {1'b0, pop};
    end
  end

  assign head       = slot_q[head_q];
  assign n_alloc    = n_alloc_q;
  assign n_unfilled = n_alloc_q - n_filled_q;

endmodule

// File: rtl/mips32_fetch.sv
// mips32_fetch: MIPS32 instruction fetch stage.
//   RESET_PC : first fetch address after reset
//   clk      : clock, all state on rising edge
//   rst      : async active-low reset
//   bus      : mips32_fetch_if.master (imem request/response, redirect, decode)
// Keeps at most two requests outstanding (queued plus still-to-be-dropped) and
// drops stale responses after a redirect by counting them in drop_q.
module mips32_fetch
  import mips32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  mips32_fetch_if.master bus
);

  logic [31:0] pc_q, pc_d;
  logic [1:0]  drop_q, drop_d;
  logic [2:0]  drop_sum;
  logic [2:0]  pending;
  logic [1:0]  n_alloc, n_unfilled;
  fetch_slot_t head;
  logic        fire, fill, pop, flush;

  assign flush   = bus.redirect_valid;
  assign pending = {1'b0, n_alloc} + {1'b0, drop_q};

  // Gated by rst so the request is quiet during reset yet up in the first
  // cycle after release.
  assign bus.imem_req_valid = rst & ~flush & (pending < 3'd2);
  assign bus.imem_req_addr  = pc_q;
  assign fire = bus.imem_req_valid & bus.imem_req_ready;
  assign fill = bus.imem_rsp_valid & (drop_q == 2'd0) & ~flush;

  assign bus.id_valid    = head.filled & ~flush;
  assign bus.id_instr    = head.instr;
  assign bus.id_pc       = head.pc;
  assign bus.id_pc_plus4 = pc_plus4(head.pc);
  assign pop = bus.id_valid & bus.id_ready;

  mips32_fetch_queue u_queue (
    .clk       (clk),
    .rst       (rst),
    .alloc     (fire),
    .alloc_pc  (pc_q),
    .fill      (fill),
    .fill_instr(bus.imem_rsp_data),
    .pop       (pop),
    .flush     (flush),
    .head      (head),
    .n_alloc   (n_alloc),
    .n_unfilled(n_unfilled)
  );

  always_comb begin
    pc_d = pc_q;
    if (flush) begin
      pc_d = {bus.redirect_pc[31:2], 2'b00};
    end else if (fire) begin
      pc_d = pc_plus4(pc_q);
    end
  end

  // On redirect every unfilled slot becomes a response to throw away; a
  // response arriving in the redirect cycle itself is already accounted for.
  always_comb begin
    drop_sum = {1'b0, drop_q} + {1'b0, n_unfilled};
    drop_d   = drop_q;
    if (flush) begin
      if (bus.imem_rsp_valid && (drop_sum != 3'd0)) begin
        drop_sum = drop_sum - 3'd1;
      end
      drop_d = (drop_sum > 3'd2) ? 2'd2 : drop_sum[1:0];
    end else if (bus.imem_rsp_valid && (drop_q != 2'd0)) begin
      drop_d = drop_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q   <= RESET_PC;
      drop_q <= 2'd0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end

endmodule

// File: tb/tb_mips32_fetch.sv
// tb_mips32_fetch: directed bench for mips32_fetch. Two instances: default
// RESET_PC and RESET_PC = 0xFFFF_FFF8. Each has a fixed-latency in-order
// memory model whose word at address a is a + 0xA000_0000.
module tb_mips32_fetch;
  import mips32_pkg::*;

  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; logic [31:0] pc4; } cap_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  pend_t       pend1[$], pend2[$];
  logic [31:0] fired1[$], fired2[$];
  cap_t        cap1[$], cap2[$];
  int          cyc1 = 0, cyc2 = 0;
  int          lat1 = 1, lat2 = 1;

  mips32_fetch_if f1 ();
  mips32_fetch_if f2 ();

  mips32_fetch u_dut (.clk(clk), .rst(rst), .bus(f1));
  mips32_fetch #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (.clk(clk), .rst(rst), .bus(f2));

  always #5 clk = ~clk;

  // Memory model + monitor, instance 1.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      if (f1.imem_req_valid && f1.imem_req_ready) begin
        pend1.push_back('{f1.imem_req_addr, cyc1 + lat1});
        fired1.push_back(f1.imem_req_addr);
      end
      if (f1.id_valid && f1.id_ready) cap1.push_back('{f1.id_pc, f1.id_instr, f1.id_pc_plus4});
    end
    cyc1++;
  end

  initial begin
    f1.imem_rsp_valid = 1'b0;
    f1.imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pend1.delete();
        f1.imem_rsp_valid = 1'b0;
      end else if (pend1.size() > 0 && pend1[0].due == cyc1) begin
        f1.imem_rsp_valid = 1'b1;
        f1.imem_rsp_data  = pend1[0].addr + 32'hA000_0000;
        void'(pend1.pop_front());
      end else begin
        f1.imem_rsp_valid = 1'b0;
      end
    end
  end

  // Memory model + monitor, instance 2.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      if (f2.imem_req_valid && f2.imem_req_ready) begin
        pend2.push_back('{f2.imem_req_addr, cyc2 + lat2});
        fired2.push_back(f2.imem_req_addr);
      end
      if (f2.id_valid && f2.id_ready) cap2.push_back('{f2.id_pc, f2.id_instr, f2.id_pc_plus4});
    end
    cyc2++;
  end

  initial begin
    f2.imem_rsp_valid = 1'b0;
    f2.imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pend2.delete();
        f2.imem_rsp_valid = 1'b0;
      end else if (pend2.size() > 0 && pend2[0].due == cyc2) begin
        f2.imem_rsp_valid = 1'b1;
        f2.imem_rsp_data  = pend2[0].addr + 32'hA000_0000;
        void'(pend2.pop_front());
      end else begin
        f2.imem_rsp_valid = 1'b0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    fired1.delete(); cap1.delete(); fired2.delete(); cap2.delete();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_caps1(input int n, input int budget);
    for (int c = 0; c < budget && cap1.size() < n; c++) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    n_cmp++; if (f1.imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rst_req_valid: got %b want 0", f1.imem_req_valid); end
    n_cmp++; if (f1.id_valid !== 1'b0) begin n_err++; $display("FAIL rst_id_valid: got %b want 0", f1.id_valid); end
    n_cmp++; if (f1.id_instr !== 32'h0) begin n_err++; $display("FAIL rst_id_instr: got %h want 0", f1.id_instr); end
    n_cmp++; if (f1.id_pc !== 32'h0) begin n_err++; $display("FAIL rst_id_pc: got %h want 0", f1.id_pc); end
    n_cmp++; if (f1.id_pc_plus4 !== 32'h4) begin n_err++; $display("FAIL rst_id_pc_plus4: got %h want 4", f1.id_pc_plus4); end
    n_cmp++; if (f1.imem_req_addr !== 32'h0) begin n_err++; $display("FAIL rst_req_addr: got %h want 0", f1.imem_req_addr); end
    n_cmp++; if (f2.imem_req_addr !== 32'hFFFF_FFF8) begin n_err++; $display("FAIL rst_wrap_req_addr: got %h want fffffff8", f2.imem_req_addr); end
    n_cmp++; if (f2.imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rst_wrap_req_valid: got %b want 0", f2.imem_req_valid); end
  endtask

  task automatic test_first_fetch();
    logic [31:0] exp_a [3] = '{32'h0, 32'h4, 32'h8};
    lat1 = 1; f1.imem_req_ready = 1'b1; f1.id_ready = 1'b1;
    do_reset();
    #1;
    n_cmp++; if (f1.imem_req_valid !== 1'b1) begin n_err++; $display("FAIL first_req_valid: got %b want 1", f1.imem_req_valid); end
    n_cmp++; if (f1.imem_req_addr !== 32'h0) begin n_err++; $display("FAIL first_req_addr: got %h want 0", f1.imem_req_addr); end
    repeat (8) @(negedge clk);
    n_cmp++;
    if (fired1.size() < 3) begin
      n_err++; $display("FAIL first_fetch_count: got %0d want >= 3", fired1.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (fired1[i] !== exp_a[i]) begin n_err++; $display("FAIL first_fetch_addr[%0d]: got %h want %h", i, fired1[i], exp_a[i]); end
      end
    end
  endtask

  task automatic test_stream();
    lat1 = 1; f1.imem_req_ready = 1'b1; f1.id_ready = 1'b1;
    do_reset();
    wait_caps1(10, 80);
    n_cmp++; if (cap1.size() < 10) begin n_err++; $display("FAIL stream_count: got %0d want 10", cap1.size()); end
    for (int i = 0; i < 10 && i < cap1.size(); i++) begin
      n_cmp++; if (cap1[i].pc !== 32'(4 * i)) begin n_err++; $display("FAIL stream_pc[%0d]: got %h want %h", i, cap1[i].pc, 32'(4 * i)); end
      n_cmp++; if (cap1[i].instr !== 32'(4 * i) + 32'hA000_0000) begin n_err++; $display("FAIL stream_instr[%0d]: got %h want %h", i, cap1[i].instr, 32'(4 * i) + 32'hA000_0000); end
      n_cmp++; if (cap1[i].pc4 !== 32'(4 * i + 4)) begin n_err++; $display("FAIL stream_pc4[%0d]: got %h want %h", i, cap1[i].pc4, 32'(4 * i + 4)); end
    end
  endtask

  task automatic test_stall();
    lat1 = 1; f1.imem_req_ready = 1'b1; f1.id_ready = 1'b1;
    do_reset();
    wait_caps1(3, 40);
    f1.id_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++; if (f1.id_valid !== 1'b1) begin n_err++; $display("FAIL stall_id_valid[%0d]: got %b want 1", k, f1.id_valid); end
      n_cmp++; if (f1.id_pc !== 32'hC) begin n_err++; $display("FAIL stall_id_pc[%0d]: got %h want c", k, f1.id_pc); end
      n_cmp++; if (f1.id_instr !== 32'hA000_000C) begin n_err++; $display("FAIL stall_id_instr[%0d]: got %h want a000000c", k, f1.id_instr); end
      n_cmp++; if (fired1.size() - cap1.size() > 2) begin n_err++; $display("FAIL stall_outstanding[%0d]: got %0d want <= 2", k, fired1.size() - cap1.size()); end
      @(negedge clk);
    end
    n_cmp++; if (fired1.size() !== 5) begin n_err++; $display("FAIL stall_fired: got %0d want 5", fired1.size()); end
    n_cmp++; if (cap1.size() !== 3) begin n_err++; $display("FAIL stall_popped: got %0d want 3", cap1.size()); end
    f1.id_ready = 1'b1;
    wait_caps1(10, 80);
    n_cmp++; if (cap1.size() < 10) begin n_err++; $display("FAIL stall_resume_count: got %0d want 10", cap1.size()); end
    for (int i = 0; i < 10 && i < cap1.size(); i++) begin
      n_cmp++; if (cap1[i].pc !== 32'(4 * i)) begin n_err++; $display("FAIL stall_seq_pc[%0d]: got %h want %h", i, cap1[i].pc, 32'(4 * i)); end
    end
  endtask

  task automatic test_redirect();
    lat1 = 3; f1.imem_req_ready = 1'b1; f1.id_ready = 1'b1;
    do_reset();
    repeat (2) @(negedge clk);
    f1.redirect_valid = 1'b1; f1.redirect_pc = 32'h100;
    #1;
    n_cmp++; if (fired1.size() !== 2) begin n_err++; $display("FAIL redir_inflight: got %0d want 2", fired1.size()); end
    n_cmp++; if (f1.imem_req_valid !== 1'b0) begin n_err++; $display("FAIL redir_req_valid: got %b want 0", f1.imem_req_valid); end
    n_cmp++; if (f1.id_valid !== 1'b0) begin n_err++; $display("FAIL redir_id_valid: got %b want 0", f1.id_valid); end
    @(negedge clk);
    f1.redirect_valid = 1'b0;
    wait_caps1(1, 40);
    n_cmp++;
    if (cap1.size() < 1) begin
      n_err++; $display("FAIL redir_timeout: got %0d want 1 instr", cap1.size());
    end else begin
      n_cmp++; if (cap1[0].pc !== 32'h100) begin n_err++; $display("FAIL redir_id_pc: got %h want 100", cap1[0].pc); end
      n_cmp++; if (cap1[0].pc4 !== 32'h104) begin n_err++; $display("FAIL redir_id_pc_plus4: got %h want 104", cap1[0].pc4); end
      n_cmp++; if (cap1[0].instr !== 32'hA000_0100) begin n_err++; $display("FAIL redir_id_instr: got %h want a0000100", cap1[0].instr); end
    end
    n_cmp++; if (fired1.size() < 3 || fired1[2] !== 32'h100) begin n_err++; $display("FAIL redir_fetch_addr: got %h want 100", (fired1.size() > 2) ? fired1[2] : 32'hx); end
    lat1 = 1;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_a [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    int nf, nc;
    lat2 = 1; f2.imem_req_ready = 1'b1; f2.id_ready = 1'b1;
    do_reset();
    #1;
    n_cmp++; if (f2.imem_req_addr !== 32'hFFFF_FFF8) begin n_err++; $display("FAIL wrap_first_addr: got %h want fffffff8", f2.imem_req_addr); end
    repeat (8) @(negedge clk);
    n_cmp++;
    if (fired2.size() < 3) begin
      n_err++; $display("FAIL wrap_count: got %0d want >= 3", fired2.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (fired2[i] !== exp_a[i]) begin n_err++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, fired2[i], exp_a[i]); end
      end
    end
    // Held redirect: the last cycle's address must win, low bits cleared.
    f2.redirect_valid = 1'b1; f2.redirect_pc = 32'h303;
    #1; nf = fired2.size(); nc = cap2.size();
    @(negedge clk);
    f2.redirect_pc = 32'h203;
    @(negedge clk);
    f2.redirect_valid = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++; if (fired2.size() <= nf || fired2[nf] !== 32'h200) begin n_err++; $display("FAIL wrap_redir_addr: got %h want 200", (fired2.size() > nf) ? fired2[nf] : 32'hx); end
    n_cmp++; if (cap2.size() <= nc || cap2[nc].pc !== 32'h200) begin n_err++; $display("FAIL wrap_redir_id_pc: got %h want 200", (cap2.size() > nc) ? cap2[nc].pc : 32'hx); end
    n_cmp++; if (cap2.size() <= nc || cap2[nc].pc4 !== 32'h204) begin n_err++; $display("FAIL wrap_redir_id_pc4: got %h want 204", (cap2.size() > nc) ? cap2[nc].pc4 : 32'hx); end
    f2.imem_req_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    lat1 = 1; f1.imem_req_ready = 1'b1; f1.id_ready = 1'b1;
    do_reset();
    wait_caps1(3, 40);
    f1.id_ready = 1'b0;
    repeat (4) @(negedge clk);
    f1.imem_req_ready = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (f1.id_pc !== 32'hC) begin n_err++; $display("FAIL rmid_pre_id_pc: got %h want c", f1.id_pc); end
    n_cmp++; if (f1.imem_req_addr !== 32'h14) begin n_err++; $display("FAIL rmid_pre_addr: got %h want 14", f1.imem_req_addr); end
    rst = 1'b0;
    #1;
    n_cmp++; if (f1.imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rmid_req_valid: got %b want 0", f1.imem_req_valid); end
    n_cmp++; if (f1.id_valid !== 1'b0) begin n_err++; $display("FAIL rmid_id_valid: got %b want 0", f1.id_valid); end
    n_cmp++; if (f1.id_pc !== 32'h0) begin n_err++; $display("FAIL rmid_id_pc: got %h want 0", f1.id_pc); end
    n_cmp++; if (f1.id_instr !== 32'h0) begin n_err++; $display("FAIL rmid_id_instr: got %h want 0", f1.id_instr); end
    n_cmp++; if (f1.id_pc_plus4 !== 32'h4) begin n_err++; $display("FAIL rmid_id_pc_plus4: got %h want 4", f1.id_pc_plus4); end
    n_cmp++; if (f1.imem_req_addr !== 32'h0) begin n_err++; $display("FAIL rmid_req_addr: got %h want 0", f1.imem_req_addr); end
    repeat (2) @(negedge clk);
    #1;
    fired1.delete(); cap1.delete();
    f1.imem_req_ready = 1'b1; f1.id_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++; if (f1.imem_req_valid !== 1'b1 || f1.imem_req_addr !== 32'h0) begin n_err++; $display("FAIL rmid_restart: got valid %b addr %h want 1 0", f1.imem_req_valid, f1.imem_req_addr); end
    wait_caps1(2, 40);
    n_cmp++; if (cap1.size() < 2 || cap1[0].pc !== 32'h0 || cap1[1].pc !== 32'h4) begin n_err++; $display("FAIL rmid_restart_seq: got %0d instrs want pcs 0,4", cap1.size()); end
  endtask

  initial begin
    f1.imem_req_ready = 1'b0; f1.redirect_valid = 1'b0; f1.redirect_pc = 32'h0; f1.id_ready = 1'b0;
    f2.imem_req_ready = 1'b0; f2.redirect_valid = 1'b0; f2.redirect_pc = 32'h0; f2.id_ready = 1'b0;
    test_reset();
    test_first_fetch();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mips32_fetch.md
MIPS32_FETCH -- requirements
Module: mips32_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous assertion, active-low.
REQ-004 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-005 SHALL have port imem_req_ready  input  1  instruction memory accepts request.
REQ-006 SHALL have port imem_req_addr  output  32  word-aligned fetch address.
REQ-007 SHALL have port imem_rsp_valid  input  1  response valid; in order, latency >= 1 cycle, no backpressure.
REQ-008 SHALL have port imem_rsp_data  input  32  fetched instruction word.
REQ-009 SHALL have port redirect_valid  input  1  taken branch/jump from EX; flush and restart.
REQ-010 SHALL have port redirect_pc  input  32  restart address.
REQ-011 SHALL have port id_ready  input  1  decode accepts; low = hazard stall.
REQ-012 SHALL have port id_valid  output  1  instruction valid to decode.
REQ-013 SHALL have ports id_instr, id_pc, id_pc_plus4  output  32 each  instruction, its address, address+4.

Function
REQ-014 SHALL hold PC register; request fires when imem_req_valid & imem_req_ready; PC then advances by 4 modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
REQ-015 SHALL allocate a 2-entry queue slot {pc, instr, filled=0} at each fired request; responses fill the oldest unfilled slot in order.
REQ-016 SHALL drive imem_req_valid = !redirect_valid & (allocated + drop_cnt < 2); imem_req_addr = PC.
REQ-017 SHALL drive id_valid = head slot filled & !redirect_valid; id_instr/id_pc from head; id_pc_plus4 = id_pc + 4 modulo 2^32.
REQ-018 SHALL pop head on id_valid & id_ready; pop and new allocation in the same cycle both take effect.
REQ-019 SHALL, while id_ready low, hold id_* outputs stable and lose no instruction; queue stops requesting when 2 slots allocated.
REQ-020 SHALL, on redirect_valid, free all slots, set PC = {redirect_pc[31:2], 2'b00}, drop_cnt_next = drop_cnt + unfilled_slots - imem_rsp_valid.
REQ-021 SHALL discard a response (no queue write) when drop_cnt > 0, decrementing drop_cnt; drop_cnt range 0..2.
REQ-022 SHALL issue redirect target request no earlier than the cycle after redirect_valid.
REQ-023 SHALL treat redirect_valid held for several cycles as repeated redirects; last redirect_pc wins.
REQ-024 SHALL keep imem_req_addr stable while imem_req_valid high and imem_req_ready low, unless redirect occurs.

Reset
REQ-025 SHALL, while rst low, force PC = RESET_PC, queue empty, drop_cnt = 0, imem_req_valid = 0, id_valid = 0, id_instr/id_pc = 0, id_pc_plus4 = 4.
REQ-026 SHALL, on reset mid-operation, discard in-flight responses arriving after reset release only if memory is also reset (memory reset is required together with fetch).
REQ-027 SHALL issue first request at RESET_PC in the first cycle after rst deasserts.

Structure
REQ-028 SHALL take RESET_PC default and fetch-slot struct {pc, instr, filled} from shared package mips32_pkg.
REQ-029 SHALL implement the 2-entry slot queue as sub-module mips32_fetch_queue (alloc, fill, pop, flush, counts).
REQ-030 SHALL contain no latches; all state flops asynchronous-reset on rst low.

Verification
REQ-031 SHALL cover: release rst, imem_req_ready=1 -> first imem_req_addr = RESET_PC, next 0x4, 0x8.
REQ-032 SHALL cover: 1-cycle memory, id_ready=1 for 10 instrs -> id_pc 0x0..0x24 in order, instr matches memory, no gaps after warm-up.
REQ-033 SHALL cover: id_ready=0 for 5 cycles mid-stream -> max 2 slots allocated, id_* stable, sequence resumes without loss or duplicate.
REQ-034 SHALL cover: 2 requests in flight, redirect_pc=0x100 -> both responses dropped, next id_pc = 0x100, id_pc_plus4 = 0x104.
REQ-035 SHALL cover: RESET_PC=0xFFFF_FFF8 -> fetch addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; redirect_pc=0x203 -> fetch 0x200.
REQ-036 SHALL cover: rst asserted with full queue and imem_req_ready=0 -> all outputs at reset values immediately, restart at RESET_PC.
